// File: rtl/inert_pkg.sv
// Shared FSM state encoding and SPI command words for the inertial sensor sequencer.
package inert_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        WR_INT_CFG,
        WR_ACCEL,
        WR_GYRO,
        WR_ROUND,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH
    } state_t;

    localparam logic [15:0] CMD_INT_CFG = 16'h0D02;
    localparam logic [15:0] CMD_ACCEL   = 16'h1053;
    localparam logic [15:0] CMD_GYRO    = 16'h1150;
    localparam logic [15:0] CMD_ROUND   = 16'h1460;
    localparam logic [15:0] CMD_RD_PL   = 16'hA200;
    localparam logic [15:0] CMD_RD_PH   = 16'hA300;
    localparam logic [15:0] CMD_RD_AL   = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH   = 16'hAD00;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the sensor interrupt level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: power-up delay, four config writes, then interrupt-driven
// four-byte pitch-rate / Z-accel reads over an external SPI master.
//
// state      | meaning
// INIT_WAIT  | power-up delay, timer counting
// WR_INT_CFG | write 0D02 outstanding
// WR_ACCEL   | write 1053 outstanding
// WR_GYRO    | write 1150 outstanding
// WR_ROUND   | write 1460 outstanding
// WAIT_INT   | idle, waiting for synchronized INT
// RD_PL      | pitch low byte read outstanding
// RD_PH      | pitch high byte read outstanding
// RD_AL      | AZ low byte read outstanding
// RD_AH      | AZ high byte read outstanding
module inert_seq
    import inert_pkg::*;
#(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic               int_sync;
    logic               wrt_nxt, vld_nxt;
    logic [15:0]        cmd_nxt;
    logic [7:0]         pitch_l, pitch_h, az_l;
    logic               unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .q     (int_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_WAIT;
            tmr   <= '0;
            wrt   <= 1'b0;
            vld   <= 1'b0;
            cmd   <= 16'h0000;
        end else begin
            state <= state_nxt;
            tmr   <= (state == INIT_WAIT && !(&tmr)) ? tmr + 1'b1 : '0;
            wrt   <= wrt_nxt;
            vld   <= vld_nxt;
            cmd   <= cmd_nxt;
        end
    end

    // done only advances states that have a transaction outstanding
    always_comb begin
        state_nxt = state;
        case (state)
            INIT_WAIT:  if (&tmr)    state_nxt = WR_INT_CFG;
            WR_INT_CFG: if (done)    state_nxt = WR_ACCEL;
            WR_ACCEL:   if (done)    state_nxt = WR_GYRO;
            WR_GYRO:    if (done)    state_nxt = WR_ROUND;
            WR_ROUND:   if (done)    state_nxt = WAIT_INT;
            WAIT_INT:   if (int_sync) state_nxt = RD_PL;
            RD_PL:      if (done)    state_nxt = RD_PH;
            RD_PH:      if (done)    state_nxt = RD_AL;
            RD_AL:      if (done)    state_nxt = RD_AH;
            RD_AH:      if (done)    state_nxt = WAIT_INT;
            default:                 state_nxt = INIT_WAIT;
        endcase
    end

    // Every transition into a transaction state launches that state's command.
    always_comb begin
        wrt_nxt = 1'b0;
        vld_nxt = 1'b0;
        cmd_nxt = cmd;
        if (state_nxt != state) begin
            case (state_nxt)
                WR_INT_CFG: begin wrt_nxt = 1'b1; cmd_nxt = CMD_INT_CFG; end
                WR_ACCEL:   begin wrt_nxt = 1'b1; cmd_nxt = CMD_ACCEL;   end
                WR_GYRO:    begin wrt_nxt = 1'b1; cmd_nxt = CMD_GYRO;    end
                WR_ROUND:   begin wrt_nxt = 1'b1; cmd_nxt = CMD_ROUND;   end
                RD_PL:      begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_PL;   end
                RD_PH:      begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_PH;   end
                RD_AL:      begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_AL;   end
                RD_AH:      begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_AH;   end
                WAIT_INT:   vld_nxt = (state == RD_AH);
                default:    ;
            endcase
        end
    end

    // The AZH byte goes straight into AZ[15:8]; the published pair updates only on that done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pitch_l <= 8'h00;
            pitch_h <= 8'h00;
            az_l    <= 8'h00;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
        end else if (done) begin
            case (state)
                RD_PL: pitch_l <= rd_data[7:0];
                RD_PH: pitch_h <= rd_data[7:0];
                RD_AL: az_l    <= rd_data[7:0];
                RD_AH: begin
                    ptch_rt <= {pitch_h, pitch_l};
                    AZ      <= {rd_data[7:0], az_l};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_seq.sv
// Randomized bench for inert_seq acting as SPI master/sensor; expected commands and
// sample pairs come from the command lists and the bytes the bench itself returns.
module tb_inert_seq;

    localparam int TMR_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld;
    logic [15:0] cmd, ptch_rt, AZ;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_ptch = 16'h0000;
    logic [15:0] exp_az   = 16'h0000;
    logic [15:0] init_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_cmds   [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    inert_seq #(.TMR_W(TMR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(input int max, input bit noise, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (wrt) break;
            if (noise) begin
                INT  = 1'($urandom);
                done = 1'($urandom);
            end
        end
        done = 1'b0;
        chk("wrt_seen", {31'd0, wrt}, 32'd1);
    endtask

    // Called with wrt sampled high; returns on the sample right after done.
    task automatic do_txn(input logic [15:0] exp_cmd, input logic [15:0] data, input int lat);
        chk("wrt_pulse", {31'd0, wrt}, 32'd1);
        chk("cmd", {16'd0, cmd}, {16'd0, exp_cmd});
        chk("vld_idle", {31'd0, vld}, 32'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("wrt_outst", {31'd0, wrt}, 32'd0);
            chk("cmd_hold", {16'd0, cmd}, {16'd0, exp_cmd});
            chk("out_hold", {ptch_rt, AZ}, {exp_ptch, exp_az});
        end
        done = 1'b1;
        rd_data = data;
        tick();
        done = 1'b0;
        rd_data = 16'($urandom);
    endtask

    task automatic idle(input int cycles, input bit noise);
        for (int i = 0; i < cycles; i++) begin
            if (noise) done = 1'($urandom);
            tick();
            chk("idle_wrt", {31'd0, wrt}, 32'd0);
            chk("idle_vld", {31'd0, vld}, 32'd0);
            chk("idle_out", {ptch_rt, AZ}, {exp_ptch, exp_az});
        end
        done = 1'b0;
    endtask

    // Call immediately after reset release.
    task automatic run_init();
        int n;
        wait_wrt(40, 1'b1, n);
        chk("init_delay", n, 32'd16);
        for (int i = 0; i < 3; i++) begin
            INT = 1'($urandom);
            do_txn(init_cmds[i], 16'($urandom), $urandom_range(1, 5));
        end
        INT = 1'b0;
        do_txn(init_cmds[3], 16'($urandom), $urandom_range(1, 5));
        chk("init_end_wrt", {31'd0, wrt}, 32'd0);
        chk("init_end_out", {ptch_rt, AZ}, {exp_ptch, exp_az});
    endtask

    task automatic start_read();
        int n;
        INT = 1'b1;
        wait_wrt(10, 1'b0, n);
        chk("int_latency", n, 32'd3);
    endtask

    task automatic do_reads(input logic [15:0] d [4], input bit drop_int);
        for (int i = 0; i < 4; i++) begin
            if (i == 0 && drop_int) INT = 1'b0;
            do_txn(rd_cmds[i], d[i], $urandom_range(1, 5));
        end
        exp_ptch = {d[1][7:0], d[0][7:0]};
        exp_az   = {d[3][7:0], d[2][7:0]};
        chk("vld_pulse", {31'd0, vld}, 32'd1);
        chk("ptch_rt", {16'd0, ptch_rt}, {16'd0, exp_ptch});
        chk("AZ", {16'd0, AZ}, {16'd0, exp_az});
        chk("vld_no_wrt", {31'd0, wrt}, 32'd0);
        tick();
        chk("vld_one_cycle", {31'd0, vld}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {wrt, vld, cmd, 14'd0}, 32'd0);
        chk({tag, "_data"}, {ptch_rt, AZ}, 32'd0);
    endtask

    initial begin
        logic [15:0] d [4];

        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        run_init();
        idle(4, 1'b1);

        d = '{16'hAB34, 16'h5512, 16'h0078, 16'hC356};
        start_read();
        do_reads(d, 1'b1);
        chk("directed_pair", {ptch_rt, AZ}, 32'h1234_5678);
        chk("drop_no_wrt", {31'd0, wrt}, 32'd0);
        idle(6, 1'b1);

        start_read();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
            do_reads(d, r == 7);
        end
        chk("cont_end_no_wrt", {31'd0, wrt}, 32'd0);
        idle(5, 1'b1);

        d = '{16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80};
        start_read();
        do_reads(d, 1'b1);
        chk("hi_byte_ignored", {ptch_rt, AZ}, 32'h8080_8080);
        idle(3, 1'b0);

        for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
        start_read();
        INT = 1'b0;
        do_txn(rd_cmds[0], d[0], $urandom_range(1, 5));
        do_txn(rd_cmds[1], d[1], $urandom_range(1, 5));
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        exp_ptch = 16'h0000;
        exp_az   = 16'h0000;
        repeat (3) tick();
        check_zero("mid_reset_hold");
        rst_n = 1'b1;
        run_init();
        idle(3, 1'b1);
        for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
        start_read();
        do_reads(d, 1'b1);
        idle(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
